// File: rtl/matrix_fb_if.sv
// Host write/commit and display read signals of the double-buffered 8x8 frame buffer.
// The host/controller side takes master and the frame buffer takes slave.
interface matrix_fb_if;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       commit;
  logic       swap_pending;
  logic       swap_done;
  logic       forced_swap;
  logic [2:0] disp_addr;
  logic [7:0] disp_data;

  modport master (
    output wr_en, wr_row, wr_data, commit, disp_addr,
    input  wr_ready, swap_pending, swap_done, forced_swap, disp_data
  );

  modport slave (
    input  wr_en, wr_row, wr_data, commit, disp_addr,
    output wr_ready, swap_pending, swap_done, forced_swap, disp_data
  );
endinterface

// File: rtl/matrix_fb.sv
// Double-buffered 8x8 frame buffer: the host fills the back bank, and a commit swaps
// banks on the display's 7->0 row wrap (or after a timeout) so no frame is shown half-written.
module matrix_fb #(
  parameter int SYNC_STAGES  = 2,
  parameter int SWAP_TIMEOUT = 4194304,
  parameter int TO_W         = 23
) (
  input  logic        clk,
  input  logic        reset,
  matrix_fb_if.slave  fb
);

  typedef enum logic {IDLE, PEND} state_t;
  typedef enum logic {BANK_A, BANK_B} bank_t;

  localparam logic [TO_W-1:0] TO_LAST =
    (SWAP_TIMEOUT == 0) ? '0 : TO_W'(SWAP_TIMEOUT - 1);

  state_t          state, state_nx;
  bank_t           front_sel;
  logic [7:0]      bank_a [8];
  logic [7:0]      bank_b [8];
  logic [2:0]      sync_q [SYNC_STAGES];
  logic [TO_W-1:0] to_cnt;
  logic            swap_done_q;
  logic            forced_q;

  logic write_ok, accept_commit, boundary, timeout;
  logic swap_now, swap_forced;

  assign write_ok      = fb.wr_en  && fb.wr_ready;
  assign accept_commit = fb.commit && fb.wr_ready;
  assign boundary      = (sync_q[SYNC_STAGES-1] == 3'd7) && (sync_q[SYNC_STAGES-2] == 3'd0);
  assign timeout       = (SWAP_TIMEOUT != 0) && (to_cnt == TO_LAST);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    swap_now    = 1'b0;
    swap_forced = 1'b0;
    case (state)
      IDLE: if (accept_commit) state_nx = PEND;
      PEND: begin
        if (boundary) begin
          state_nx = IDLE;
          swap_now = 1'b1;
        end else if (timeout) begin
          state_nx    = IDLE;
          swap_now    = 1'b1;
          swap_forced = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      front_sel   <= BANK_A;
      swap_done_q <= 1'b0;
      forced_q    <= 1'b0;
      to_cnt      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      // NOTE: the banks are real registers whose cleared contents are displayed, so they are reset.
      for (int r = 0; r < 8; r++) begin
        bank_a[r] <= '0;
        bank_b[r] <= '0;
      end
    end else begin
      sync_q[0] <= fb.disp_addr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];

      swap_done_q <= swap_now;
      if (swap_now) front_sel <= (front_sel == BANK_A) ? BANK_B : BANK_A;

      if (accept_commit)    forced_q <= 1'b0;
      else if (swap_forced) forced_q <= 1'b1;

      if (state == IDLE)        to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

      // The write is applied before pending sets, so a write paired with commit is kept.
      if (write_ok) begin
        if (front_sel == BANK_A) bank_b[fb.wr_row] <= fb.wr_data;
        else                     bank_a[fb.wr_row] <= fb.wr_data;
      end
    end
  end

  always_comb begin
    fb.wr_ready     = (state == IDLE);
    fb.swap_pending = (state == PEND);
    fb.swap_done    = swap_done_q;
    fb.forced_swap  = forced_q;
    fb.disp_data    = (front_sel == BANK_A) ? bank_a[fb.disp_addr] : bank_b[fb.disp_addr];
  end

endmodule

// File: tb/tb_matrix_fb.sv
// Directed bench for matrix_fb: a default-timeout instance for reads/commit/boundary behaviour
// and a SWAP_TIMEOUT=16 instance for forced swaps. Expected reads come from a bench-side model.
module tb_matrix_fb;
  localparam int SYNC = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  matrix_fb_if bus();
  matrix_fb_if bus_to();

  matrix_fb #(.SYNC_STAGES(SYNC), .SWAP_TIMEOUT(4194304), .TO_W(23)) dut (
    .clk(clk), .reset(reset), .fb(bus)
  );

  matrix_fb #(.SYNC_STAGES(SYNC), .SWAP_TIMEOUT(16), .TO_W(5)) dut_to (
    .clk(clk), .reset(reset), .fb(bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] m_bank [2][8];
  int         m_front;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_front = 0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) m_bank[b][r] = 8'h00;
  endtask

  task automatic read_check(input logic [2:0] a, input string tag);
    bus.disp_addr = a;
    exp_q.push_back(m_bank[m_front][a]);
    #1;
    check(tag, bus.disp_data, exp_q.pop_front());
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 8; a++) begin
      read_check(3'(a), tag);
      tick();
    end
  endtask

  task automatic write_row(input logic [2:0] row, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_row  = row;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic hold_addr(input logic [2:0] a, input int n);
    bus.disp_addr = a;
    repeat (n) tick();
  endtask

  // Applies disp_addr=0 right after an edge; swap_done must be high after SYNC edges,
  // i.e. in the (SYNC+1)th cycle counting the cycle the address was applied.
  task automatic wrap_and_expect(input string tag, input int exp_pulses);
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    bus.disp_addr = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.swap_done) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check({tag, " swap_done pulses"}, pulses, exp_pulses);
    if (exp_pulses > 0) check({tag, " swap_done latency"}, first, SYNC);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    model_clear();
    reset = 1'b0;
    bus.wr_en = 0; bus.wr_row = 0; bus.wr_data = 0; bus.commit = 0; bus.disp_addr = 0;
    bus_to.wr_en = 0; bus_to.wr_row = 0; bus_to.wr_data = 0; bus_to.commit = 0; bus_to.disp_addr = 0;

    // Reset state
    repeat (2) tick();
    reset = 1'b1;
    check("reset wr_ready", bus.wr_ready, 1);
    check("reset swap_pending", bus.swap_pending, 0);
    check("reset swap_done", bus.swap_done, 0);
    check("reset forced_swap", bus.forced_swap, 0);
    check("reset to forced_swap", bus_to.forced_swap, 0);
    sweep("reset read");

    // Fill back bank; nothing visible before a swap
    for (int r = 0; r < 8; r++) begin
      write_row(3'(r), 8'h01 << r);
      m_bank[1][r] = 8'h01 << r;
    end
    sweep("pre-commit read");

    // Commit, then ignored write and ignored second commit while pending
    bus.disp_addr = 3'd5;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    check("commit pending", bus.swap_pending, 1);
    check("pending wr_ready", bus.wr_ready, 0);
    bus.wr_en = 1'b1; bus.wr_row = 3'd2; bus.wr_data = 8'hFF; bus.commit = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.commit = 1'b0;
    hold_addr(3'd5, 2);
    check("pending at 5", bus.swap_pending, 1);
    hold_addr(3'd6, 4);
    check("pending at 6", bus.swap_pending, 1);
    hold_addr(3'd7, 4);
    check("pending at 7", bus.swap_pending, 1);
    wrap_and_expect("first swap", 1);
    m_front = 1;
    check("after swap pending", bus.swap_pending, 0);
    check("after swap forced", bus.forced_swap, 0);
    read_check(3'd3, "row3 after swap");
    read_check(3'd2, "row2 ignored write");

    // Non-sequential jumps are not boundaries
    write_row(3'd1, 8'hA5);
    m_bank[0][1] = 8'hA5;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    hold_addr(3'd7, 4);
    hold_addr(3'd4, 4);
    check("jump 7->4 pending", bus.swap_pending, 1);
    hold_addr(3'd2, 4);
    hold_addr(3'd0, 4);
    check("jump 2->0 pending", bus.swap_pending, 1);
    hold_addr(3'd7, 4);
    wrap_and_expect("wrap swap", 1);
    m_front = 0;
    read_check(3'd1, "row1 new front");
    read_check(3'd3, "row3 new front");

    // Forced swap after 16 cycles in PEND
    bus_to.disp_addr = 3'd3;
    bus_to.commit = 1'b1;
    tick();
    bus_to.commit = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus_to.swap_pending) break;
      n++;
      tick();
    end
    check("timeout cycles in PEND", n, 16);
    check("timeout swap_done", bus_to.swap_done, 1);
    check("timeout forced_swap", bus_to.forced_swap, 1);

    // Next commit clears forced_swap; boundary coinciding with timeout is not forced
    bus_to.disp_addr = 3'd7;
    repeat (3) tick();
    bus_to.commit = 1'b1;
    tick();
    bus_to.commit = 1'b0;
    check("commit clears forced", bus_to.forced_swap, 0);
    repeat (14) tick();
    bus_to.disp_addr = 3'd0;
    tick();
    check("coincide pending", bus_to.swap_pending, 1);
    tick();
    check("coincide swap_done", bus_to.swap_done, 1);
    check("coincide pending clr", bus_to.swap_pending, 0);
    check("coincide forced", bus_to.forced_swap, 0);

    // Reset mid-commit drops the pending swap and clears both banks
    bus.disp_addr = 3'd3;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    check("pre-reset pending", bus.swap_pending, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_clear();
    check("mid reset pending", bus.swap_pending, 0);
    check("mid reset wr_ready", bus.wr_ready, 1);
    check("mid reset swap_done", bus.swap_done, 0);
    hold_addr(3'd7, 3);
    wrap_and_expect("post reset wrap", 0);
    sweep("post reset read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/matrix_fb.md
Name: matrix_fb

Overview:
- Double-buffered 8x8 frame buffer that services the display read port of the LED matrix controller.
- It answers disp_addr with disp_data.
- The host side writes rows into a back buffer, then requests a commit. The buffers swap only at a frame boundary, which is the controller's disp_addr wrapping 7->0, so the display never shows a half-written frame.
- It sits between the host/pattern logic and the matrix controller.

Parameters:
- SYNC_STAGES, 2, number of flops used to resample disp_addr before boundary detection (allowed range 2..3).
- SWAP_TIMEOUT, 4194304, clk cycles a pending commit waits for a frame boundary before a forced swap. 0 disables the forced swap.
- TO_W, 23, width of the timeout counter. It must hold SWAP_TIMEOUT.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- wr_en  in  1  write strobe for the back buffer.
- wr_row  in  3  row index for the write.
- wr_data  in  8  row pattern, bit n = column n.
- wr_ready  out  1  1 = a write or commit is accepted this cycle.
- commit  in  1  request to swap the buffers at the next frame boundary.
- swap_pending  out  1  a commit is accepted and the swap has not happened yet.
- swap_done  out  1  one-cycle pulse in the cycle after the swap takes effect.
- forced_swap  out  1  sticky flag; a swap was forced by timeout. Cleared by the next accepted commit.
- disp_addr  in  3  row address from the matrix controller.
- disp_data  out  8  row pattern from the front buffer.

Behaviour:
- Storage:
  - Two banks of 8x8-bit registers, A and B.
  - front_sel selects the front bank; the other bank is the back bank.
- Reset (reset==0 at a clk edge):
  - Both banks cleared to 8'h00; front_sel=A.
  - swap_pending=0, swap_done=0, forced_swap=0, wr_ready=1.
  - Sync chain and timeout counter cleared.
  - Reset mid-commit drops the pending swap.
- Read path:
  - disp_data = front[disp_addr], purely combinational from the unsynchronised disp_addr. No latency, because the controller samples it without a handshake.
  - disp_data changes only on disp_addr change or on a swap.
- Write path (wr_en && wr_ready at a clk edge):
  - back[wr_row] <= wr_data. Visible in the front bank only after a swap.
  - Writes with wr_ready=0 are ignored; there is no queueing.
- wr_ready = ~swap_pending.
- Commit:
  - commit && wr_ready at a clk edge -> swap_pending=1 and the timeout counter loads 0.
  - commit with swap_pending=1 is ignored.
  - wr_en and commit in the same accepted cycle: the write lands first, then pending sets.
- Boundary detect:
  - disp_addr passes through SYNC_STAGES flops: s[0]..s[N-1].
  - Boundary = (s[N-1]==3'd7) && (s[N-2]==3'd0), i.e. the 7->0 wrap seen on synchronised values.
  - Other address changes, including non-sequential jumps, are not boundaries.
- FSM, two states:
  - IDLE -> PEND on accepted commit.
  - PEND -> IDLE on boundary, or on timeout when SWAP_TIMEOUT!=0 and the counter == SWAP_TIMEOUT-1.
  - Boundary and timeout in the same cycle count as a boundary swap; forced_swap stays 0.
- Swap, in the cycle leaving PEND:
  - front_sel toggles and swap_pending clears.
  - swap_done=1 for exactly the next cycle.
  - forced_swap sets if the swap came from timeout.
- After a swap the new back bank holds the previously displayed frame. It is not cleared; the host must rewrite every row it wants changed.
- Timeout counter:
  - Counts only in PEND and saturates at SWAP_TIMEOUT-1.
  - Held at 0 in IDLE.
- Commit in the same cycle as a boundary while IDLE: pending sets. That boundary is not used; the swap waits for the next boundary.

Test Plan:
- Reset with reset=0 for 2 cycles, then sweep disp_addr 0..7 -> disp_data=8'h00 for all rows; wr_ready=1, swap_pending=0.
- Write rows 0..7 with 8'h01<<row, no commit, sweep disp_addr -> disp_data stays 8'h00. Then commit and step disp_addr 5,6,7,0 with 4 clk per step -> swap_pending=1 until 7->0 is seen. swap_done pulses once SYNC_STAGES+1 cycles after disp_addr=0 is applied. Afterwards disp_addr=3 gives disp_data=8'h08.
- While swap_pending=1, wr_en with wr_row=2 and wr_data=8'hFF -> ignored; after the swap the back row 2 still holds the pre-commit value. A second commit is ignored and gives no extra swap_done.
- SWAP_TIMEOUT=16, commit with disp_addr held at 3 -> swap after 16 cycles in PEND and forced_swap=1. The next commit clears forced_swap.
- disp_addr jumps 7->4 and 2->0 -> no swap. Only 7->0 causes a swap; boundary and timeout in the same cycle -> forced_swap=0.
- Drive reset=0 for 1 cycle while swap_pending=1 -> swap_pending=0, no swap_done, front=A, all rows read 8'h00.
